// File: rtl/iir_biquad_mc_pkg.sv
// Shared definitions for the multi-channel biquad: tap/coefficient select
// encodings, FSM states and the default fixed-point formats.
package iir_biquad_mc_pkg;

  localparam int DEF_IN_W      = 8;
  localparam int DEF_IN_FRAC   = 6;
  localparam int DEF_OUT_W     = 17;
  localparam int DEF_OUT_FRAC  = 15;
  localparam int DEF_COEF_W    = 16;
  localparam int DEF_COEF_FRAC = 14;

  localparam int NUM_TAPS = 5;

  // Tap order is also the MAC order: b0, b1, b2, a1, a2.
  typedef enum logic [2:0] {
    SEL_B0 = 3'd0,
    SEL_B1 = 3'd1,
    SEL_B2 = 3'd2,
    SEL_A1 = 3'd3,
    SEL_A2 = 3'd4
  } coef_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iir_round_sat.sv
// Round half up, arithmetic shift right by SHIFT and saturate an accumulator
// to a narrower signed output; sat flags a clamp.
module iir_round_sat #(
  parameter int ACC_W = 40,
  parameter int OUT_W = 17,
  parameter int SHIFT = 14
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  localparam logic signed [ACC_W:0] RND =
    {{(ACC_W-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [ACC_W:0] MAX_EXT =
    {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_EXT =
    {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] shifted;

  // One guard bit keeps the rounding add from wrapping near full scale.
  always_comb begin
    rounded = {acc[ACC_W-1], acc} + RND;
    shifted = rounded >>> SHIFT;
    sat     = 1'b0;
    y       = shifted[OUT_W-1:0];
    if (shifted > MAX_EXT) begin
      y   = MAX_EXT[OUT_W-1:0];
      sat = 1'b1;
    end else if (shifted < MIN_EXT) begin
      y   = MIN_EXT[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/iir_biquad_mc.sv
// Multi-channel programmable biquad IIR: one shared MAC walks the five taps,
// per-channel delay lines, rounded and saturated output.
module iir_biquad_mc
  import iir_biquad_mc_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int IN_FRAC   = DEF_IN_FRAC,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int OUT_FRAC  = DEF_OUT_FRAC,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int COEF_FRAC = DEF_COEF_FRAC,
  parameter int CHANNELS  = 4,
  parameter int ACC_W     = 40,
  localparam int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CHAN_W-1:0]        in_chan,
  input  logic signed [IN_W-1:0]   in_data,
  output logic                     out_valid,
  output logic [CHAN_W-1:0]        out_chan,
  output logic signed [OUT_W-1:0]  out_data,
  input  logic                     coef_we,
  input  logic [2:0]               coef_sel,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     clear_state,
  output logic                     sat_flag
);

  localparam int XSH       = OUT_FRAC - IN_FRAC;
  localparam int CHAN_SPAN = 1 << CHAN_W;
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) << COEF_FRAC;

  state_t state, state_nxt;
  logic [2:0]              k;
  logic [CHAN_W-1:0]       chan_cur;
  logic                    chan_ok_cur;
  logic [CHAN_SPAN-1:0]    chan_ok_vec;
  logic signed [IN_W-1:0]  x_cur, x1_cur, x2_cur;
  logic signed [OUT_W-1:0] y1_cur, y2_cur, y_sat;
  logic signed [ACC_W-1:0] acc, op, cf, prod;
  logic                    sat_hit, accept;

  logic signed [COEF_W-1:0] coef   [NUM_TAPS];
  logic signed [IN_W-1:0]   x1_mem [CHANNELS];
  logic signed [IN_W-1:0]   x2_mem [CHANNELS];
  logic signed [OUT_W-1:0]  y1_mem [CHANNELS];
  logic signed [OUT_W-1:0]  y2_mem [CHANNELS];

  assign accept = (state == ST_IDLE) && in_valid && !clear_state;

  // Channel codes beyond CHANNELS are accepted but never touch state.
  always_comb begin
    for (int i = 0; i < CHAN_SPAN; i++) chan_ok_vec[i] = (i < CHANNELS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear_state) state_nxt = ST_IDLE;
    else begin
      unique case (state)
        ST_IDLE: if (in_valid) state_nxt = ST_MAC;
        ST_MAC:  if (k == 3'(NUM_TAPS - 1)) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb in_ready = (state == ST_IDLE);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    op = '0;
    cf = '0;
    case (coef_sel_t'(k))
      SEL_B0: begin op = ACC_W'(x_cur)  <<< XSH; cf = ACC_W'(coef[0]); end
      SEL_B1: begin op = ACC_W'(x1_cur) <<< XSH; cf = ACC_W'(coef[1]); end
      SEL_B2: begin op = ACC_W'(x2_cur) <<< XSH; cf = ACC_W'(coef[2]); end
      SEL_A1: begin op = ACC_W'(y1_cur);         cf = ACC_W'(coef[3]); end
      SEL_A2: begin op = ACC_W'(y2_cur);         cf = ACC_W'(coef[4]); end
      default: ;
    endcase
    prod = op * cf;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k           <= '0;
      chan_cur    <= '0;
      chan_ok_cur <= 1'b0;
      x_cur       <= '0;
      x1_cur      <= '0;
      x2_cur      <= '0;
      y1_cur      <= '0;
      y2_cur      <= '0;
      acc         <= '0;
    end else if (accept) begin
      k           <= '0;
      acc         <= '0;
      chan_cur    <= in_chan;
      chan_ok_cur <= chan_ok_vec[in_chan];
      x_cur       <= in_data;
      x1_cur      <= chan_ok_vec[in_chan] ? x1_mem[in_chan] : '0;
      x2_cur      <= chan_ok_vec[in_chan] ? x2_mem[in_chan] : '0;
      y1_cur      <= chan_ok_vec[in_chan] ? y1_mem[in_chan] : '0;
      y2_cur      <= chan_ok_vec[in_chan] ? y2_mem[in_chan] : '0;
    end else if (state == ST_MAC) begin
      acc <= acc + prod;
      k   <= k + 3'd1;
    end
  end

  iir_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (COEF_FRAC)
  ) u_round_sat (
    .acc (acc),
    .y   (y_sat),
    .sat (sat_hit)
  );

  // NOTE: these arrays are small register banks, not RAM, so they take the async reset directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TAPS; i++) coef[i] <= (i == 0) ? COEF_ONE : '0;
    end else if (state == ST_IDLE && coef_we && coef_sel <= SEL_A2) begin
      coef[coef_sel] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        x1_mem[i] <= '0;
        x2_mem[i] <= '0;
        y1_mem[i] <= '0;
        y2_mem[i] <= '0;
      end
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clear_state) begin
        for (int i = 0; i < CHANNELS; i++) begin
          x1_mem[i] <= '0;
          x2_mem[i] <= '0;
          y1_mem[i] <= '0;
          y2_mem[i] <= '0;
        end
        sat_flag <= 1'b0;
      end else if (state == ST_DONE && chan_ok_cur) begin
        out_valid          <= 1'b1;
        out_chan           <= chan_cur;
        out_data           <= y_sat;
        sat_flag           <= sat_flag | sat_hit;
        x2_mem[chan_cur]   <= x1_cur;
        x1_mem[chan_cur]   <= x_cur;
        y2_mem[chan_cur]   <= y1_cur;
        y1_mem[chan_cur]   <= y_sat;
      end
    end
  end

endmodule

// File: doc/iir_biquad_mc.md
# iir_biquad_mc

Parametrised, multi-channel, second-order (biquad) IIR filter using one shared multiplier-accumulator, time-multiplexed over the five taps. Coefficients are programmable at run time. Each channel has its own delay-line state. The block sits between the sample source and downstream DSP, and extends the fixed-coefficient single-channel 2nd-order filter with programmability, channels, rounding and saturation.

## Interface
- `IN_W`, 8: input width, signed, `IN_FRAC` fractional bits
- `IN_FRAC`, 6: input fractional bits (default format Q2.6)
- `OUT_W`, 17: output and feedback-state width, signed (default Q2.15)
- `OUT_FRAC`, 15: output fractional bits
- `COEF_W`, 16: coefficient width, signed
- `COEF_FRAC`, 14: coefficient fractional bits
- `CHANNELS`, 4: number of independent channels
- `ACC_W`, 40: accumulator width, signed

Ports:
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous active-low reset
- `in_valid` in 1: sample offered
- `in_ready` out 1: high only in IDLE
- `in_chan` in `$clog2(CHANNELS)`: channel of offered sample
- `in_data` in `IN_W`: sample x[n]
- `out_valid` out 1: one-cycle result pulse, no backpressure
- `out_chan` out `$clog2(CHANNELS)`: channel of result
- `out_data` out `OUT_W`: y[n], held until next result
- `coef_we` in 1: coefficient write strobe
- `coef_sel` in 3: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5–7 ignored
- `coef_data` in `COEF_W`: coefficient value
- `clear_state` in 1: zero all channel state, abort in-flight sample
- `sat_flag` out 1: sticky, set on any output saturation

## Operation
- y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] + a1·y[n-1] + a2·y[n-2]. Feedback coefficients carry their own sign and are always added.
- Coefficients are shared by all channels. Per-channel state is x1, x2 (`IN_W`) and y1, y2 (`OUT_W`).
- Reset values:
  - b0 = 1<<COEF_FRAC; b1, b2, a1, a2 = 0 (pass-through)
  - all channel state = 0
  - `out_valid` = 0, `out_data` = 0, `out_chan` = 0, `sat_flag` = 0
  - `in_ready` = 1, FSM in IDLE
- FSM states and transitions:
  - IDLE → MAC on `in_valid`. The edge captures x and channel, loads that channel's state, and clears the accumulator.
  - MAC: k = 0..4 for five cycles; one product is accumulated per cycle, in tap order b0, b1, b2, a1, a2. After k = 4, go to DONE.
  - DONE → IDLE unconditionally.
- Alignment:
  - x products are shifted left by OUT_FRAC − IN_FRAC.
  - y products are used unshifted.
  - The accumulator carries OUT_FRAC + COEF_FRAC fractional bits.
- DONE edge:
  - Add 2^(COEF_FRAC−1) (round half up), then arithmetic shift right by COEF_FRAC.
  - Saturate to `OUT_W` signed (max 0x0FFFF, min 0x10000 for 17 bits) and set `sat_flag` on clamp.
  - Register `out_data`/`out_chan` and pulse `out_valid`.
  - Shift the channel state: x2←x1, x1←x, y2←y1, y1←saturated y.
- Coefficient writes take effect only in IDLE and are dropped otherwise. If `coef_we` and `in_valid` occur together in IDLE, the accepted sample uses the new coefficient.
- `in_chan` ≥ CHANNELS: the sample is accepted and discarded. There is no `out_valid` and no state change, but the FSM still runs its full sequence.
- `clear_state` (any state): on the next edge, zero all channel state, clear `sat_flag` and return to IDLE. No `out_valid` is produced for an aborted sample. Coefficients are unchanged. It takes priority over `in_valid` and over DONE.
- Asynchronous reset mid-operation restores every reset value immediately.

## Timing
- Sample accepted at edge E0. MAC accumulates at E1..E5, DONE at E6.
- `out_valid` is high in the cycle following E6. `in_ready` is high again in that same cycle.
- Minimum spacing is 7 cycles per sample. Latency from accept to result is 6 edges.
- `in_ready` is a registered function of state only and does not depend on `in_valid`.

## Structure
- Shared package holds:
  - the coefficient-select encodings (B0..A2)
  - the FSM state enum
  - a default-format constants set (IN_W/IN_FRAC/OUT_W/OUT_FRAC/COEF_W/COEF_FRAC)
- One sub-module, `iir_round_sat`: combinational round, shift and saturate from `ACC_W` to `OUT_W`, with a saturation flag. It is reusable by other filter blocks.
- The channel state and coefficient bank are register arrays inside the top module.

## Test plan
- Pass-through after reset: ch0, x = 0x40 (1.0) → `out_valid` 7 cycles later, `out_data` = 0x08000, `out_chan` = 0, `sat_flag` = 0.
- Impulse with a1 = 0x2000 (0.5): ch0, x = 0x40 then zeros → outputs 0x08000, 0x04000, 0x02000, 0x01000.
- Channel isolation: interleave the ch0 impulse with ch1 zeros → ch1 always 0x00000, ch0 sequence identical to the previous test.
- Saturation: b0 = 0x7FFF, a1 = 0x3F00, ch2, x = 0x7F repeated → output clamps to 0x0FFFF and `sat_flag` = 1. With x = 0x80 (−2.0) repeated the output reaches 0x10000.
- Abort: `clear_state` at MAC k = 2 → no `out_valid`, `in_ready` = 1 next cycle, following pass-through sample yields the clean result. `reset_n` low mid-MAC → all outputs at their reset values.
- Coefficient gating:
  - a1 write during MAC is dropped (output unchanged from the pass-through value).
  - `coef_sel` = 5 is ignored.
  - A b0 = 0x2000 write coinciding with an accepted sample applies to that sample (0x40 → 0x04000).
